// File: rtl/rgb_sequencer.sv
// Palette-driven RGB colour sequencer feeding a PWM controller's duty inputs.
// Define RGB_SEQ_FADE_EN to crossfade between palette entries instead of switching.
module rgb_sequencer #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic [1:0]  last_idx,
  input  logic [15:0] hold,
  output logic [7:0]  rout,
  output logic [7:0]  gout,
  output logic [7:0]  bout,
  output logic        busy,
  output logic        step
);

`ifdef RGB_SEQ_FADE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FADE = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;
`endif

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  state_t      state, state_n;
  logic [1:0]  idx, idx_n, nxt;
  logic [15:0] presc, presc_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] hold_eff;
  logic [7:0]  r_n, g_n, b_n;
  logic        step_n;
  logic        tick;
  logic        expire;
  logic [23:0] pal [DEPTH];

`ifdef RGB_SEQ_FADE_EN
  logic [1:0]  tgt, tgt_n;
  logic [23:0] tcol;

  function automatic logic [7:0] toward(input logic [7:0] cur, input logic [7:0] dst);
    if (cur < dst) return cur + 8'd1;
    if (cur > dst) return cur - 8'd1;
    return cur;
  endfunction

  assign tcol = pal[tgt];
`endif

  assign tick     = (presc == PRE_LAST);
  assign hold_eff = (hold == 16'd0) ? 16'd1 : hold;
  assign expire   = ({1'b0, cnt} + 17'd1) >= {1'b0, hold_eff};
  assign nxt      = (idx >= last_idx) ? 2'd0 : idx + 2'd1;
  assign busy     = (state != IDLE);

  // Palette writes land on the edge; a same-edge load still sees the old entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) pal[i] <= '0;
    end else if (wr_en) begin
      pal[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      presc <= '0;
      cnt   <= '0;
      rout  <= '0;
      gout  <= '0;
      bout  <= '0;
      step  <= 1'b0;
`ifdef RGB_SEQ_FADE_EN
      tgt   <= '0;
`endif
    end else begin
      state <= state_n;
      idx   <= idx_n;
      presc <= presc_n;
      cnt   <= cnt_n;
      rout  <= r_n;
      gout  <= g_n;
      bout  <= b_n;
      step  <= step_n;
`ifdef RGB_SEQ_FADE_EN
      tgt   <= tgt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    presc_n = tick ? '0 : presc + 16'd1;
    r_n     = rout;
    g_n     = gout;
    b_n     = bout;
    step_n  = 1'b0;
`ifdef RGB_SEQ_FADE_EN
    tgt_n   = tgt;
`endif
    unique case (state)
      IDLE: begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        if (start) begin
          state_n           = HOLD;
          idx_n             = '0;
          cnt_n             = '0;
          presc_n           = '0;
          {r_n, g_n, b_n}   = pal[0];
        end
      end
      HOLD: begin
        if (tick) begin
          if (expire) begin
            cnt_n = '0;
`ifdef RGB_SEQ_FADE_EN
            state_n = FADE;
            tgt_n   = nxt;
`else
            idx_n           = nxt;
            {r_n, g_n, b_n} = pal[nxt];
            step_n          = 1'b1;
            presc_n         = '0;
`endif
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end
`ifdef RGB_SEQ_FADE_EN
      FADE: begin
        if (tick) begin
          r_n = toward(rout, tcol[23:16]);
          g_n = toward(gout, tcol[15:8]);
          b_n = toward(bout, tcol[7:0]);
          // Arrival is judged on the stepped values so step coincides with the final move.
          if ({r_n, g_n, b_n} == tcol) begin
            state_n = HOLD;
            idx_n   = tgt;
            step_n  = 1'b1;
            cnt_n   = '0;
            presc_n = '0;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    if (stop) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
      r_n     = '0;
      g_n     = '0;
      b_n     = '0;
      step_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_rgb_sequencer.sv
// Self-checking bench for rgb_sequencer (PRESCALE=2) against a dwell-time colour model.
module tb_rgb_sequencer;

  localparam int unsigned PRE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, wr_en;
  logic [1:0]  wr_addr, last_idx;
  logic [23:0] wr_data;
  logic [15:0] hold;
  logic [7:0]  rout, gout, bout;
  logic        busy, step;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a colour is shown for PRE*max(hold,1) cycles, then the next index is entered.
  logic [23:0] mpal [4];
  logic        m_busy = 1'b0;
  logic        m_step = 1'b0;
  logic [23:0] m_col  = '0;
  int          m_idx  = 0;
  int          m_age  = 0;

  rgb_sequencer #(.PRESCALE(PRE), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_idx(last_idx), .hold(hold),
    .rout(rout), .gout(gout), .bout(bout), .busy(busy), .step(step)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int dwell;
    dwell = int'(PRE) * ((hold == 16'd0) ? 1 : int'(hold));
    if (!rst) begin
      m_busy = 1'b0; m_step = 1'b0; m_col = '0; m_idx = 0; m_age = 0;
      for (int i = 0; i < 4; i++) mpal[i] = '0;
    end else begin
      m_step = 1'b0;
      if (stop) begin
        m_busy = 1'b0; m_col = '0; m_idx = 0; m_age = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_idx = 0; m_col = mpal[0]; m_age = 0;
        end
      end else begin
        m_age++;
        if (m_age >= dwell) begin
          m_idx  = (m_idx >= int'(last_idx)) ? 0 : m_idx + 1;
          m_col  = mpal[m_idx];
          m_age  = 0;
          m_step = 1'b1;
        end
      end
      if (wr_en) mpal[wr_addr] = wr_data;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic load_basic();
    write_entry(2'd0, 24'h200000);
    write_entry(2'd1, 24'h002000);
    write_entry(2'd2, 24'h000020);
    write_entry(2'd3, 24'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; stop = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; last_idx = 2'd2; hold = 16'd3;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      n_cmp++;
      if ({rout, gout, bout, busy, step} !== 26'd0) begin
        n_bad++;
        $display("FAIL reset_hold: got rgb=%h busy=%b step=%b, want all 0", {rout, gout, bout}, busy, step);
      end
    end
    start = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_release_idle: got busy=%b, want 0", busy);
      end
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rout, gout, bout} !== 24'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_palette_clear: got rgb=%h busy=%b, want rgb=000000 busy=1", {rout, gout, bout}, busy);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_basic();
    load_basic();
    last_idx = 2'd2; hold = 16'd3;
    start = 1'b1;
    cyc();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({rout, gout, bout} !== m_col || busy !== m_busy || step !== m_step) begin
        n_bad++;
        $display("FAIL basic k=%0d: got rgb=%h busy=%b step=%b, want rgb=%h busy=%b step=%b",
                 k, {rout, gout, bout}, busy, step, m_col, m_busy, m_step);
      end
      start = ($urandom_range(0, 3) == 0);
      cyc();
    end
    start = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_hold_zero();
    for (int h = 0; h < 2; h++) begin
      hold = 16'(h);
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        n_cmp++;
        if ({rout, gout, bout} !== m_col || busy !== m_busy || step !== m_step) begin
          n_bad++;
          $display("FAIL hold%0d k=%0d: got rgb=%h step=%b, want rgb=%h step=%b",
                   h, k, {rout, gout, bout}, step, m_col, m_step);
        end
        cyc();
      end
      stop = 1'b1;
      cyc();
      stop = 1'b0;
    end
  endtask

  task automatic test_stop();
    hold = 16'd3;
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || {rout, gout, bout} !== 24'd0) begin
      n_bad++;
      $display("FAIL stop_vs_start: got busy=%b rgb=%h, want busy=0 rgb=000000", busy, {rout, gout, bout});
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || {rout, gout, bout} !== 24'd0 || step !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_mid_hold: got busy=%b rgb=%h step=%b, want 0/000000/0", busy, {rout, gout, bout}, step);
    end
  endtask

  task automatic test_live_write();
    load_basic();
    last_idx = 2'd2; hold = 16'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({rout, gout, bout} !== m_col || busy !== m_busy || step !== m_step) begin
        n_bad++;
        $display("FAIL live_write k=%0d: got rgb=%h step=%b, want rgb=%h step=%b",
                 k, {rout, gout, bout}, step, m_col, m_step);
      end
      if (k == 10) begin
        n_cmp++;
        if (gout !== 8'h20) begin
          n_bad++;
          $display("FAIL live_write_hold: got gout=%h, want 20", gout);
        end
      end
      if (k == 26) begin
        n_cmp++;
        if ({rout, gout, bout} !== 24'h0000FF) begin
          n_bad++;
          $display("FAIL live_write_reentry: got rgb=%h, want 0000ff", {rout, gout, bout});
        end
      end
      wr_en = (k == 8); wr_addr = 2'd1; wr_data = 24'h0000FF;
      cyc();
      wr_en = 1'b0;
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < 4; a++) write_entry(2'(a), 24'($urandom));
      last_idx = 2'($urandom_range(0, 3));
      hold = 16'($urandom_range(0, 3));
      start = 1'b1;
      cyc();
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        n_cmp++;
        if ({rout, gout, bout} !== m_col || busy !== m_busy || step !== m_step) begin
          n_bad++;
          $display("FAIL random t=%0d k=%0d: got rgb=%h busy=%b step=%b, want rgb=%h busy=%b step=%b",
                   t, k, {rout, gout, bout}, busy, step, m_col, m_busy, m_step);
        end
        start   = ($urandom_range(0, 3) == 0);
        stop    = ($urandom_range(0, 29) == 0);
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = 24'($urandom);
        cyc();
      end
      start = 1'b0; wr_en = 1'b0; stop = 1'b1;
      cyc();
      stop = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    load_basic();
    last_idx = 2'd2; hold = 16'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({rout, gout, bout, busy, step} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_async: got rgb=%h busy=%b step=%b, want all 0", {rout, gout, bout}, busy, step);
    end
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_no_resume: got busy=%b, want 0", busy);
      end
    end
  endtask

`ifdef RGB_SEQ_FADE_EN
  task automatic test_fade();
    write_entry(2'd0, 24'h040000);
    write_entry(2'd1, 24'h000004);
    last_idx = 2'd1; hold = 16'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      int er;
      @(negedge clk);
      er = (k < 2) ? 4 : 5 - k / 2;
      n_cmp++;
      if (rout !== 8'(er) || bout !== 8'(4 - er) || gout !== 8'd0 || step !== (k == 10)) begin
        n_bad++;
        $display("FAIL fade k=%0d: got r=%0d g=%0d b=%0d step=%b, want r=%0d g=0 b=%0d step=%b",
                 k, rout, gout, bout, step, er, 4 - er, (k == 10));
      end
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stop();
`ifdef RGB_SEQ_FADE_EN
    test_fade();
`else
    test_basic();
    test_hold_zero();
    test_live_write();
    test_random();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
